ir_issue_ctrl: RTL

Sequencer between the decode stage and the issue queue: it accepts decoded instructions, buffers them in a 2-entry FIFO and drives the instruction-register side of the IQ handshake (`control_word`, `ld_iq`, `rvfi`). It honors `issue_q_full_n` back-pressure and `ack_o` acceptance, and drops buffered work on a pipeline flush. It also provides an issue sequence tag and a stall-cycle counter for performance monitoring.

---
 rtl/ir_issue_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/ir_issue_ctrl.sv
// rtl/ir_issue_ctrl.sv - decode-to-issue-queue sequencer with 2-entry buffer
package tomasula_types;
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } ctl_word;
endpackage

package rv32i_types;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } rvfi_word;
endpackage

module ir_issue_ctrl
    import tomasula_types::*, rv32i_types::*;
#(
    parameter int SEQ_W   = 6,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dec_valid,
    input  ctl_word            dec_ctl,
    input  rvfi_word           dec_rvfi,
    output logic               dec_ready,
    input  logic               flush,
    input  logic               issue_q_full_n,
    input  logic               ack_o,
    output ctl_word            control_word,
    output logic               ld_iq,
    output rvfi_word           rvfi,
    output logic [SEQ_W-1:0]   issue_seq,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state, state_nx;
    logic               push, pop;
    ctl_word            head_ctl, tail_ctl;
    rvfi_word           head_rvfi, tail_rvfi;
    logic [SEQ_W-1:0]   head_tag, tail_tag;
    logic [SEQ_W-1:0]   tag_cnt;
    logic [STALL_W-1:0] stall_q;

    always_comb begin
        state_nx  = state;
        dec_ready = (state != TWO);
        ld_iq     = (state != EMPTY) && issue_q_full_n && !flush;
        push      = dec_valid && dec_ready && !flush;
        pop       = ld_iq && ack_o;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (push) state_nx = ONE;
                ONE: begin
                    if (push && !pop)      state_nx = TWO;
                    else if (!push && pop) state_nx = EMPTY;
                end
                TWO:     if (pop) state_nx = ONE;
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            head_ctl  <= '0;
            head_rvfi <= '0;
            head_tag  <= '0;
            tail_ctl  <= '0;
            tail_rvfi <= '0;
            tail_tag  <= '0;
            tag_cnt   <= '0;
            stall_q   <= '0;
        end else begin
            state <= state_nx;
            if (push) tag_cnt <= tag_cnt + SEQ_W'(1);
            if ((state != EMPTY) && !issue_q_full_n && (stall_q != {STALL_W{1'b1}}))
                stall_q <= stall_q + STALL_W'(1);
            // A push lands in the head when the head slot is free or being vacated this edge.
            if (push && ((state == EMPTY) || ((state == ONE) && pop))) begin
                head_ctl  <= dec_ctl;
                head_rvfi <= dec_rvfi;
                head_tag  <= tag_cnt;
            end else if (pop && (state == TWO)) begin
                head_ctl  <= tail_ctl;
                head_rvfi <= tail_rvfi;
                head_tag  <= tail_tag;
            end
            if (push && (state == ONE) && !pop) begin
                tail_ctl  <= dec_ctl;
                tail_rvfi <= dec_rvfi;
                tail_tag  <= tag_cnt;
            end
        end
    end

    assign control_word = (state != EMPTY) ? head_ctl  : '0;
    assign rvfi         = (state != EMPTY) ? head_rvfi : '0;
    assign issue_seq    = (state != EMPTY) ? head_tag  : '0;
    assign stall_cnt    = stall_q;

endmodule
